alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Responder end of the ALU operation interface: accepts one command per cycle (opcode, operand A, operand B) over a valid/ready channel.
- Computes the result in a 2-stage pipeline and returns results in order through a valid/ready response channel, buffered by an internal result FIFO.
- Sits behind the testbench driver / bus front-end. Results feed the monitor and scoreboard path.
- Opcode encoding follows the team's ALU opcode type: ADD=0, SUB=1, PASSA=2, PASSB=3, NEGA=4. Operands and result are 16 bits.

Parameters:
- DEPTH, 4, result FIFO entries (power of 2, ≥2).
- CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  core can accept command
- cmd_op  in  3  opcode
- cmd_a  in  16  operand A
- cmd_b  in  16  operand B
- rsp_valid  out  1  result available at FIFO head
- rsp_ready  in  1  consumer takes result
- rsp_result  out  16  result
- rsp_error  out  1  result came from an illegal opcode
- busy  out  1  stage1 valid or FIFO non-empty
- err_count  out  CNT_W  number of illegal opcodes accepted, saturating

Behaviour:
- Reset (async assert, sync deassert internally): stage1 valid=0, FIFO empty, rd/wr pointers=0, err_count=0.
  - Outputs during reset: cmd_ready=0, rsp_valid=0, rsp_result=0, rsp_error=0, busy=0.
  - cmd_ready rises the first cycle after rst_n deasserts.
- Accept: a command transfers on a rising edge with cmd_valid&cmd_ready.
  - cmd_ready = (fifo_count + stage1_valid) < DEPTH. It is computed from registered state only.
  - A pop in the same cycle does not free a slot for that cycle (conservative).
  - cmd_valid held while cmd_ready=0 must not alter any state.
- Stage1 (edge k, the accept edge): latch op, a, b; stage1_valid=1. If there is no accept at an edge, stage1_valid=0.
- Stage2 (edge k+1): compute and write {error, result} into the FIFO. rsp_valid is visible in the cycle after edge k+1 when the FIFO was empty. Minimum latency: accept edge → pop possible at edge k+2.
- Arithmetic (all modulo 2^16, no flags):
  - ADD a+b; SUB a−b; PASSA a; PASSB b; NEGA 0−a.
  - Opcodes 5–7: result 16'h0000, error=1. err_count increments at the stage2 write and saturates at all-ones.
- Response: rsp_valid = FIFO non-empty. rsp_result/rsp_error show the head entry, held stable while rsp_valid & !rsp_ready.
  - Pop on edge with rsp_valid&rsp_ready.
  - Results emerge strictly in accept order.
- FIFO:
  - Pointers wrap modulo DEPTH; count range 0..DEPTH.
  - Simultaneous write and pop at any count (including full and single-entry) leaves count unchanged and preserves order.
  - Overflow is impossible by the cmd_ready rule; under no condition is an entry overwritten.
- Back-to-back: with rsp_ready held high, throughput is 1 command/cycle indefinitely.
- busy = stage1_valid | (fifo_count != 0).
- Reset mid-operation: in-flight and buffered results are discarded, with no response emitted for them. Post-reset behaviour is identical to power-up.

Test Plan:
- Single ops, rsp_ready=1: ADD 0x0003+0x0004 → 0x0007; SUB 0x0000−0x0001 → 0xFFFF; ADD 0xFFFF+0x0001 → 0x0000; NEGA a=0x0001 → 0xFFFF; PASSB b=0xBEEF → 0xBEEF. Each result is poppable 2 edges after accept, rsp_error=0.
- Illegal opcode 6, a=0x1234: rsp_result=0x0000, rsp_error=1, err_count=1. Issue 300 illegal ops with CNT_W=8: err_count=255.
- Backpressure: rsp_ready=0 with continuous cmd_valid. Exactly DEPTH (4) commands accepted, then cmd_ready=0. Head stays stable. Releasing rsp_ready drains all 4 in order, and cmd_ready reasserts.
- Streaming: 64 random commands, rsp_ready toggling randomly. Results match the reference model in order, none lost or duplicated. Simultaneous push/pop at full count keeps count=DEPTH.
- Reset mid-stream: assert rst_n=0 with 3 results buffered. rsp_valid, busy and cmd_ready drop to 0 immediately (async). After release, FIFO is empty, and the first new ADD 1+1 returns 0x0002.

Source files
------------

// File: rtl/alu_core.sv
// alu_core: responder end of the ALU operation interface.
// Commands are latched in stage1, computed and written into a small result
// FIFO in stage2, and handed back in accept order over a valid/ready channel.
module alu_core #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic             rsp_error,
  output logic             busy,
  output logic [CNT_W-1:0] err_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_PASSA = 3'd2;
  localparam logic [2:0] OP_PASSB = 3'd3;
  localparam logic [2:0] OP_NEGA  = 3'd4;

  logic          ready_en;
  logic          s1_valid;
  logic [2:0]    s1_op;
  logic [15:0]   s1_a;
  logic [15:0]   s1_b;
  logic [15:0]   s2_result;
  logic          s2_error;
  logic [15:0]   mem_res [DEPTH];
  logic          mem_err [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occupancy;
  logic          accept;
  logic          push;
  logic          pop;

  // Holds cmd_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Stage1 is counted as occupied so a later push can never overflow the FIFO;
  // a pop in the same cycle is deliberately not credited.
  assign occupancy = fifo_count + CW'(s1_valid);
  assign cmd_ready = ready_en & (occupancy < CW'(DEPTH));
  assign accept    = cmd_valid & cmd_ready;
  assign push      = s1_valid;
  assign pop       = rsp_valid & rsp_ready;

  // Stage1: capture the accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op <= cmd_op;
        s1_a  <= cmd_a;
        s1_b  <= cmd_b;
      end
    end
  end

  // Stage2 arithmetic, modulo 2^16; undefined opcodes yield zero with error set.
  always_comb begin
    s2_result = '0;
    s2_error  = 1'b0;
    case (s1_op)
      OP_ADD:   s2_result = s1_a + s1_b;
      OP_SUB:   s2_result = s1_a - s1_b;
      OP_PASSA: s2_result = s1_a;
      OP_PASSB: s2_result = s1_b;
      OP_NEGA:  s2_result = 16'h0000 - s1_a;
      default:  s2_error  = 1'b1;
    endcase
  end

  // FIFO storage; contents are only observable through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_res[wr_ptr] <= s2_result;
      mem_err[wr_ptr] <= s2_error;
    end
  end

  // FIFO pointers and count; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Saturating count of illegal opcodes, bumped when the result is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  err_count <= '0;
    else if (push && s2_error && (err_count != '1)) err_count <= err_count + CNT_W'(1);
  end

  assign rsp_valid  = (fifo_count != '0);
  assign rsp_result = rsp_valid ? mem_res[rd_ptr] : 16'h0000;
  assign rsp_error  = rsp_valid ? mem_err[rd_ptr] : 1'b0;
  assign busy       = s1_valid | (fifo_count != '0);

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: single ops, illegal opcodes, backpressure,
// random streaming against a reference model, and reset mid-stream.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_error;
  logic        busy;
  logic [7:0]  err_count;

  int n_chk  = 0;
  int n_pass = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  alu_core #(.DEPTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_error  (rsp_error),
    .busy       (busy),
    .err_count  (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      3'd0:    return {1'b0, 16'(a + b)};
      3'd1:    return {1'b0, 16'(a - b)};
      3'd2:    return {1'b0, a};
      3'd3:    return {1'b0, b};
      3'd4:    return {1'b0, 16'(16'h0000 - a)};
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  // One command with rsp_ready high; result must appear after the second edge.
  task automatic do_single(input string tag, input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] exp_res,
                           input logic exp_err);
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_a = a; cmd_b = b;
    chk({tag, "_rdy"}, cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk({tag, "_early"}, rsp_valid, 0);
    step();
    chk({tag, "_vld"}, rsp_valid, 1);
    chk({tag, "_res"}, rsp_result, exp_res);
    chk({tag, "_err"}, rsp_error, exp_err);
    step();
    chk({tag, "_popped"}, rsp_valid, 0);
  endtask

  initial begin
    int acc, cyc, sent, recv;
    bit acc_now;
    logic [15:0] held;

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_count", err_count, 0);
    repeat (3) step();
    rst_n = 1'b1;
    chk("rel_ready_low", cmd_ready, 0);
    step();
    chk("rel_ready_high", cmd_ready, 1);

    do_single("add", 3'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0);
    do_single("sub", 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0);
    do_single("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    do_single("nega", 3'd4, 16'h0001, 16'h0000, 16'hFFFF, 1'b0);
    do_single("passb", 3'd3, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0);
    do_single("passa", 3'd2, 16'h5A5A, 16'h1111, 16'h5A5A, 1'b0);
    do_single("illegal", 3'd6, 16'h1234, 16'h0000, 16'h0000, 1'b1);
    chk("err_count_1", err_count, 1);

    // 299 more illegal ops back-to-back: saturation and 1/cycle throughput.
    acc = 0; cyc = 0;
    cmd_valid = 1'b1; cmd_op = 3'd7; cmd_a = 16'h0001; cmd_b = 16'h0002;
    while (acc < 299 && cyc < 1000) begin
      if (cmd_ready) acc++;
      step();
      cyc++;
    end
    cmd_valid = 1'b0;
    chk("ill_accepts", acc, 299);
    chk("b2b_cycles", cyc, 299);
    repeat (3) step();
    chk("err_count_sat", err_count, 255);
    chk("ill_drained", busy, 0);

    // Backpressure: exactly DEPTH accepts, head held, drain in order.
    exp_q.delete();
    rsp_ready = 1'b0;
    acc = 0;
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_b = 16'h0100; cmd_a = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready) begin
        exp_q.push_back({1'b0, 16'h0100 + 16'(acc)});
        acc++;
      end
      step();
      cmd_a = 16'(acc);
    end
    chk("bp_accepts", acc, 4);
    chk("bp_ready_low", cmd_ready, 0);
    held = rsp_result;
    step();
    chk("bp_head", rsp_result, 16'h0100);
    chk("bp_head_stable", rsp_result, held);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_vld", rsp_valid, 1);
      chk("bp_drain_res", {rsp_error, rsp_result}, exp_q[i]);
      step();
    end
    chk("bp_empty", rsp_valid, 0);
    chk("bp_ready_back", cmd_ready, 1);

    // Random streaming with random response backpressure.
    exp_q.delete();
    sent = 0; recv = 0; cyc = 0;
    rsp_ready = 1'($urandom_range(0, 1));
    cmd_valid = 1'b1;
    cmd_op = 3'($urandom_range(0, 7)); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
    while ((sent < 64 || recv < sent) && cyc < 3000) begin
      acc_now = cmd_valid && cmd_ready;
      if (acc_now) begin
        exp_q.push_back(ref_alu(cmd_op, cmd_a, cmd_b));
        sent++;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("stream_extra", 1, 0);
        else chk("stream_res", {rsp_error, rsp_result}, exp_q.pop_front());
        recv++;
      end
      step();
      cyc++;
      rsp_ready = 1'($urandom_range(0, 1));
      if (acc_now) begin
        if (sent < 64) begin
          cmd_op = 3'($urandom_range(0, 7)); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    chk("stream_timeout", (cyc < 3000) ? 1 : 0, 1);
    chk("stream_recv", recv, 64);
    chk("stream_q_empty", exp_q.size(), 0);
    step();
    chk("stream_idle", busy, 0);

    // Reset with three results buffered.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 16'h0010; cmd_b = 16'h0001;
    repeat (3) step();
    cmd_valid = 1'b0;
    repeat (2) step();
    chk("pre_rst_vld", rsp_valid, 1);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_res", rsp_result, 0);
    chk("mid_rst_errcnt", err_count, 0);
    repeat (2) step();
    rst_n = 1'b1;
    chk("post_rst_ready_low", cmd_ready, 0);
    step();
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_vld", rsp_valid, 0);
    do_single("post_rst_add", 3'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
